// File: rtl/head_position_tracker.sv
// rtl/head_position_tracker.sv - decodes stepper coil phases into head track, track-0 and settle status
module head_position_tracker #(
    parameter int MAX_TRACK    = 79,
    parameter int SETTLE_COUNT = 25,
    parameter int TRACK_W      = 7
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [3:0]         coils,
    input  logic               fault_clr,
    output logic [TRACK_W-1:0] track,
    output logic               tr0,
    output logic               busy,
    output logic               step_done,
    output logic               fault
);

    localparam logic [TRACK_W-1:0] MAX_T         = TRACK_W'(MAX_TRACK);
    localparam logic [7:0]         SETTLE_RELOAD = 8'(SETTLE_COUNT);

    typedef enum logic {
        IDLE,
        SETTLE
    } state_t;

    state_t             state;
    logic [7:0]         counter;
    logic [3:0]         prev;
    logic               one_hot;
    logic               is_in;
    logic               is_out;
    logic               is_opp;
    logic               is_step;
    logic               fault_evt;
    logic [TRACK_W-1:0] track_nxt;

    // prev is always one-hot, so an exact match against a rotation implies coils is one-hot too
    always_comb begin
        one_hot   = (coils != 4'd0) && ((coils & (coils - 4'd1)) == 4'd0);
        is_in     = (coils == {prev[2:0], prev[3]});
        is_out    = (coils == {prev[0], prev[3:1]});
        is_opp    = (coils == {prev[1:0], prev[3:2]});
        is_step   = is_in || is_out;
        fault_evt = !one_hot || is_opp;
        track_nxt = track;
        if (is_in && (track != MAX_T)) begin
            track_nxt = track + TRACK_W'(1);
        end else if (is_out && (track != '0)) begin
            track_nxt = track - TRACK_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev      <= 4'b0001;
            track     <= '0;
            tr0       <= 1'b1;
            busy      <= 1'b0;
            step_done <= 1'b0;
            fault     <= 1'b0;
            state     <= IDLE;
            counter   <= 8'd0;
        end else begin
            // a new fault event outranks a simultaneous clear
            fault <= fault_evt || (fault && !fault_clr);

            if (is_step || is_opp) begin
                prev <= coils;
            end

            if (is_step) begin
                track     <= track_nxt;
                tr0       <= (track_nxt == '0);
                state     <= SETTLE;
                counter   <= SETTLE_RELOAD;
                busy      <= 1'b1;
                step_done <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        busy      <= 1'b0;
                        step_done <= 1'b0;
                    end
                    SETTLE: begin
                        if (counter == 8'd0) begin
                            state     <= IDLE;
                            busy      <= 1'b0;
                            step_done <= 1'b1;
                        end else begin
                            counter   <= counter - 8'd1;
                            busy      <= 1'b1;
                            step_done <= 1'b0;
                        end
                    end
                    default: begin
                        state     <= IDLE;
                        busy      <= 1'b0;
                        step_done <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_head_position_tracker.sv
// tb/tb_head_position_tracker.sv - directed and randomized checks against a phase-index reference model
module tb_head_position_tracker;

    localparam int MAX_TRACK    = 79;
    localparam int SETTLE_COUNT = 25;
    localparam int TRACK_W      = 7;
    localparam int IDLE_SINCE   = 1000;

    logic               clk = 1'b0;
    logic               rst;
    logic [3:0]         coils;
    logic               fault_clr;
    logic [TRACK_W-1:0] track;
    logic               tr0;
    logic               busy;
    logic               step_done;
    logic               fault;

    int checks = 0;
    int errors = 0;

    int m_track;
    int m_pidx;
    int m_since;
    bit m_fault;
    int done_seen;

    head_position_tracker #(
        .MAX_TRACK   (MAX_TRACK),
        .SETTLE_COUNT(SETTLE_COUNT),
        .TRACK_W     (TRACK_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .coils    (coils),
        .fault_clr(fault_clr),
        .track    (track),
        .tr0      (tr0),
        .busy     (busy),
        .step_done(step_done),
        .fault    (fault)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_track = 0;
        m_pidx  = 0;
        m_since = IDLE_SINCE;
        m_fault = 1'b0;
    endtask

    // Reference: head position is an integer clamped to [0, MAX_TRACK]; phase is an index mod 4
    task automatic model_edge();
        int cidx;
        int d;
        bit evt;
        evt = 1'b0;
        if (m_since < IDLE_SINCE) m_since++;
        if ($countones(coils) != 1) begin
            evt = 1'b1;
        end else begin
            cidx = 0;
            for (int i = 0; i < 4; i++) if (coils[i]) cidx = i;
            d = (cidx - m_pidx + 4) % 4;
            if (d == 1) begin
                m_track = (m_track + 1 > MAX_TRACK) ? MAX_TRACK : m_track + 1;
                m_since = 0;
                m_pidx  = cidx;
            end else if (d == 3) begin
                m_track = (m_track - 1 < 0) ? 0 : m_track - 1;
                m_since = 0;
                m_pidx  = cidx;
            end else if (d == 2) begin
                evt    = 1'b1;
                m_pidx = cidx;
            end
        end
        m_fault = evt ? 1'b1 : (fault_clr ? 1'b0 : m_fault);
    endtask

    task automatic check_all();
        check("track", 32'(track), 32'(m_track));
        check("tr0", 32'(tr0), 32'(m_track == 0));
        check("busy", 32'(busy), 32'(m_since <= SETTLE_COUNT));
        check("step_done", 32'(step_done), 32'(m_since == SETTLE_COUNT + 1));
        check("fault", 32'(fault), 32'(m_fault));
    endtask

    task automatic tick();
        @(posedge clk);
        if (!rst) model_reset();
        else model_edge();
        #1;
        if (step_done) done_seen++;
        check_all();
    endtask

    task automatic drive_phase(input int idx, input int hold);
        coils = 4'(4'b0001 << (idx % 4));
        repeat (hold) tick();
    endtask

    initial begin
        int idx;
        int r;
        int hold;
        logic [3:0] v;

        rst       = 1'b0;
        coils     = 4'b0001;
        fault_clr = 1'b0;
        model_reset();
        done_seen = 0;
        repeat (2) @(posedge clk);
        #1;
        check_all();
        rst = 1'b1;

        repeat (20) tick();

        // Inward sweep, one phase per 40 cycles
        done_seen = 0;
        for (int i = 1; i <= 4; i++) drive_phase(i, 40);
        check("in_sweep_track", 32'(track), 32'd4);
        check("in_sweep_dones", 32'(done_seen), 32'd4);

        // Back out to track 2, then three back-to-back outward steps
        drive_phase(3, 30);
        drive_phase(2, 30);
        check("out_start_track", 32'(track), 32'd2);
        done_seen = 0;
        drive_phase(1, 5);
        drive_phase(0, 5);
        drive_phase(3, 5);
        check("out_clamp_track", 32'(track), 32'd0);
        check("out_busy_held", 32'(busy), 32'd1);
        repeat (30) tick();
        check("out_single_done", 32'(done_seen), 32'd1);

        // 80 inward steps saturate at MAX_TRACK
        idx = 3;
        for (int i = 0; i < 80; i++) begin
            idx = (idx + 1) % 4;
            drive_phase(idx, 2);
        end
        repeat (30) tick();
        check("saturate_track", 32'(track), 32'(MAX_TRACK));
        check("saturate_fault", 32'(fault), 32'd0);

        // Opposite jump faults and resyncs; next adjacent phase is a real step
        drive_phase(0, 10);
        drive_phase(2, 10);
        drive_phase(3, 30);
        fault_clr = 1'b1;
        tick();
        fault_clr = 1'b0;
        tick();
        check("fault_cleared", 32'(fault), 32'd0);

        // Invalid patterns fault without moving prev; fault_clr same cycle as event loses
        coils = 4'b0000;
        tick();
        coils     = 4'b0011;
        fault_clr = 1'b1;
        tick();
        fault_clr = 1'b0;
        drive_phase(3, 5);

        // Asynchronous reset mid-settle
        drive_phase(0, 6);
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        check_all();
        coils = 4'b0001;
        repeat (3) tick();
        rst       = 1'b1;
        done_seen = 0;
        repeat (40) tick();
        check("reset_no_done", 32'(done_seen), 32'd0);

        // Randomized phase traffic
        for (int n = 0; n < 300; n++) begin
            r    = int'($urandom_range(0, 9));
            hold = int'($urandom_range(1, 30));
            if (r <= 3) begin
                coils = 4'(4'b0001 << ((m_pidx + 1) % 4));
            end else if (r <= 6) begin
                coils = 4'(4'b0001 << ((m_pidx + 3) % 4));
            end else if (r == 7) begin
                coils = 4'(4'b0001 << m_pidx);
            end else if (r == 8) begin
                coils = 4'(4'b0001 << ((m_pidx + 2) % 4));
            end else begin
                v = 4'($urandom_range(0, 15));
                while ($countones(v) == 1) v = 4'($urandom_range(0, 15));
                coils = v;
            end
            for (int h = 0; h < hold; h++) begin
                fault_clr = ($urandom_range(0, 7) == 0);
                tick();
            end
            fault_clr = 1'b0;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/head_position_tracker.md
Name: head_position_tracker

Overview:
Sits directly downstream of the floppy stepper coil driver. It consumes the 4-phase one-hot coil vector and decodes each phase advance into a head track number. It generates the track-0 sensor signal that is fed back to the coil driver's tr0 input. It also provides settle timing (busy/done) so the media/sector logic knows when the head position is stable.

Parameters:
MAX_TRACK, 79, highest reachable track; inward steps saturate here.
SETTLE_COUNT, 25, post-step settle cycles (8-bit counter; legal 0..255).
TRACK_W, 7, width of track output (must hold MAX_TRACK).

Ports:
clk  input  1  system clock; all logic rising-edge.
rst  input  1  reset, asynchronous assert, active-low (0 = reset).
coils  input  4  one-hot coil phase from the step driver, same clock domain, no synchroniser.
fault_clr  input  1  synchronous clear of sticky fault.
track  output  TRACK_W  current head track.
tr0  output  1  high when track == 0.
busy  output  1  high while the head is settling after a step.
step_done  output  1  one-cycle pulse when settling completes.
fault  output  1  sticky flag set on an illegal coil pattern or transition.

Behaviour:
- Reset (rst=0, async):
  - track=0, tr0=1, busy=0, step_done=0, fault=0.
  - Last-accepted phase register prev=4'b0001, matching the driver's reset phase.
  - State=IDLE, counter=0.
- Phase classification each cycle, comparing coils against prev:
  - SAME: coils == prev. No action.
  - IN: 1→2→4→8→1 (0001→0010→0100→1000→0001). Inward step.
  - OUT: the reverse order. Outward step.
  - OPPOSITE: valid one-hot, two phases away (0001↔0100, 0010↔1000).
  - INVALID: not one-hot (0000, multi-hot).
- IN/OUT action, latency 1:
  - Change seen in cycle N; registered results visible after edge N+1.
  - prev <= coils.
  - track increments (IN) or decrements (OUT).
  - IN at MAX_TRACK clamps at MAX_TRACK. OUT at 0 clamps at 0. No fault in either clamp case; prev still updates.
  - tr0 <= (new track == 0), registered in the same edge as track.
  - State <= SETTLE, counter <= SETTLE_COUNT, busy <= 1.
- OPPOSITE action:
  - fault <= 1, prev <= coils (resynchronise), track unchanged, no settle started.
- INVALID action:
  - fault <= 1. prev, track, and state unchanged.
- FSM states IDLE and SETTLE:
  - IDLE: busy=0. A valid IN/OUT goes to SETTLE.
  - SETTLE: busy=1. If counter==0, go to IDLE with busy<=0 and step_done<=1 for exactly one cycle. Otherwise counter decrements.
  - Total busy width is SETTLE_COUNT+1 cycles. SETTLE_COUNT=0 gives busy for 1 cycle, then the done pulse.
  - Valid IN/OUT during SETTLE: track updates and the counter reloads to SETTLE_COUNT. No step_done for the interrupted settle.
  - Step arriving on the same cycle the counter reaches 0: reload wins. Stay in SETTLE, no step_done.
- fault behaviour:
  - Sticky. fault_clr=1 clears it at the next edge.
  - A new fault event on the same cycle as fault_clr wins (fault stays 1).
- Reset mid-settle: immediately returns to reset values. The interrupted settle never produces step_done.
- Arithmetic:
  - track is unsigned TRACK_W bits; saturating, never wraps.
  - counter is 8-bit unsigned, never decremented below 0.

Test Plan:
- Reset then idle with coils=0001 -> track=0, tr0=1, busy=0, fault=0 indefinitely.
- Drive IN sequence 0010,0100,1000,0001, each held 40 cycles (SETTLE_COUNT=25):
  - track=1,2,3,4, each visible 1 cycle after the change.
  - tr0 falls with the first step.
  - busy high 26 cycles per step; one step_done per step.
- From track 2, drive OUT phases back-to-back every 5 cycles ×3:
  - track=1,0,0 (clamped); tr0=1 after the second step.
  - busy stays high continuously.
  - Exactly one step_done, 26 cycles after the last step.
- 80 IN steps from 0 with MAX_TRACK=79 -> track saturates at 79 (80th step clamps), fault=0.
- coils 0001→0100 -> fault=1, track unchanged, no busy. Next 0100→1000 is accepted as IN (track+1). Pulse fault_clr -> fault=0.
- coils=0000 then 0011 -> fault=1, prev unchanged (returning to prior phase gives no step). Assert rst=0 mid-settle -> all outputs reset asynchronously; no step_done is emitted.
